// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, constants and helpers for the UART transmit arbiter
package uart_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, WAIT_RDY, HOLD} state_e;
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: round-robin winner search starting at a rotating pointer
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] winner_o,
  output logic         any_valid_o
);
  logic [W-1:0] idx;
  assign any_valid_o = |req_i;
  // scan downward from the farthest slot so the nearest valid slot to ptr wins last
  always_comb begin
    winner_o = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (req_i[idx]) winner_o = idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART transmitter
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_load,
  input  logic                      txrdy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  state_e              state_q, state_d;
  logic [ID_W-1:0]     gid_q, gid_d, rr_q, rr_d, winner;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                last_q, last_d, load_q, load_d, busy_q, busy_d, tout_q, tout_d;
  logic                any_valid;
  logic [BYTE_W-1:0]   bytes [NUM_REQ];
  logic [ID_W-1:0]     rr_next;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end
  uart_rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req_i       (req_valid),
    .ptr_i       (rr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );
  assign rr_next     = ID_W'(next_ptr(int'(gid_q), NUM_REQ));
  assign req_ready   = (state_q == LOAD) ? NUM_REQ'(1) << gid_q : '0;
  assign tx_data     = data_q;
  assign tx_load     = load_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign timeout_err = tout_q;
  // next-state: grant, byte capture, transmitter pacing and idle-timeout release
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    load_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: if (enable && txrdy && any_valid) begin
        gid_d   = winner;
        state_d = LOAD;
      end
      LOAD: begin
        data_d  = bytes[gid_q];
        last_d  = req_last[gid_q];
        load_d  = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: if (!txrdy) state_d = WAIT_RDY;
      WAIT_RDY: if (txrdy) begin
        state_d = last_q ? IDLE : HOLD;
        rr_d    = last_q ? rr_next : rr_q;
        cnt_d   = '0;
      end
      HOLD: if (req_valid[gid_q]) state_d = LOAD;
      else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        tout_d  = 1'b1;
        state_d = IDLE;
        rr_d    = rr_next;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random packet traffic against a packet-level round-robin model
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  logic         clk = 1'b0;
  logic         reset, enable, txrdy;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic [7:0]   tx_data;
  logic         tx_load, busy, timeout_err;
  logic [1:0]   grant_id;
  int checks = 0, errors = 0;
  logic [8:0] q [N][$];
  logic [9:0] exp_q [$];
  int mptr = 0, hs_cnt = 0, lo = 0, lo_min = 1;
  bit pend = 0, rose = 0, to_ok = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_load(tx_load),
    .txrdy(txrdy), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = q[i].size() != 0;
      req_data[i*8 +: 8] = (q[i].size() != 0) ? q[i][0][7:0] : 8'h00;
      req_last[i]        = (q[i].size() != 0) ? q[i][0][8] : 1'b0;
    end
  endtask

  // one clock: handshake bookkeeping, transmitter model, load scoreboard
  task automatic step();
    logic [N-1:0] hs;
    logic [9:0]   e;
    hs = req_ready & req_valid;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i] && q[i].size() != 0) begin
        q[i].delete(0);
        hs_cnt++;
      end
    rose = 0;
    if (pend) begin
      txrdy = 1'b0;
      pend  = 0;
      lo    = $urandom_range(20, lo_min);
    end else if (!txrdy) begin
      if (lo <= 1) begin
        txrdy = 1'b1;
        rose  = 1;
      end else lo--;
    end
    if (tx_load) begin
      pend = 1;
      chk("tx_load_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("grant_id", 32'(grant_id), 32'(e[9:8]));
      end
    end
    if (!to_ok) chk("timeout_err_quiet", 32'(timeout_err), 32'd0);
    drive();
  endtask

  // whole packets leave in round-robin order of requesters holding data
  task automatic model();
    logic [8:0] c [N][$];
    logic [8:0] b;
    int w;
    bit found;
    for (int i = 0; i < N; i++) c[i] = q[i];
    forever begin
      found = 0;
      w = 0;
      for (int k = 0; k < N; k++)
        if (!found && c[(mptr + k) % N].size() != 0) begin
          w = (mptr + k) % N;
          found = 1;
        end
      if (!found) break;
      do begin
        b = c[w].pop_front();
        exp_q.push_back({2'(w), b[7:0]});
      end while (!b[8]);
      mptr = (w + 1) % N;
    end
  endtask

  task automatic run_phase();
    int n = 0;
    drive();
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      step();
      n++;
    end
    chk("phase_in_budget", 32'(n < 3000), 32'd1);
    chk("idle_after_phase", 32'(busy), 32'd0);
  endtask

  task automatic mphase();
    int nb;
    model();
    nb = exp_q.size();
    hs_cnt = 0;
    run_phase();
    chk("ready_per_byte", 32'(hs_cnt), 32'(nb));
  endtask

  task automatic wait_rise();
    int n = 0;
    do begin
      step();
      n++;
    end while (!rose && n < 200);
    chk("txrdy_rise_seen", 32'(rose), 32'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    enable = 1'b0;
    txrdy = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_load", 32'(tx_load), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    reset = 1'b0;
    enable = 1'b1;
    q[0].push_back({1'b0, 8'h55});
    q[0].push_back({1'b1, 8'hA3});
    mphase();
    q[1].push_back({1'b1, 8'h11});
    mphase();
    q[0].push_back({1'b1, 8'h20});
    q[1].push_back({1'b1, 8'h21});
    q[2].push_back({1'b1, 8'h22});
    q[2].push_back({1'b1, 8'h32});
    q[3].push_back({1'b1, 8'h23});
    mphase();
    q[0].push_back({1'b1, 8'h40});
    q[1].push_back({1'b0, 8'h41});
    q[1].push_back({1'b0, 8'h42});
    q[1].push_back({1'b1, 8'h43});
    q[2].push_back({1'b1, 8'h44});
    mphase();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(2, 0);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++) q[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      mphase();
    end
    q[3].push_back({1'b0, 8'h9C});
    exp_q.push_back({2'd3, 8'h9C});
    to_ok = 1;
    drive();
    wait_rise();
    k = 0;
    do begin
      step();
      k++;
    end while (!timeout_err && k < 40);
    chk("timeout_latency", 32'(k), 32'(TO + 1));
    chk("timeout_busy", 32'(busy), 0);
    step();
    chk("timeout_one_cycle", 32'(timeout_err), 0);
    to_ok = 0;
    mptr = 0;
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h60 + i)});
    mphase();
    q[3].push_back({1'b0, 8'h71});
    exp_q.push_back({2'd3, 8'h71});
    drive();
    wait_rise();
    repeat (TO) step();
    q[3].push_back({1'b1, 8'h72});
    exp_q.push_back({2'd3, 8'h72});
    run_phase();
    chk("boundary_drained", 32'(exp_q.size()), 0);
    mptr = 0;
    lo_min = 6;
    q[2].push_back({1'b0, 8'hB1});
    q[2].push_back({1'b1, 8'hB2});
    exp_q.push_back({2'd2, 8'hB1});
    drive();
    k = 0;
    do begin
      step();
      k++;
    end while (txrdy && k < 200);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    enable = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tx_load", 32'(tx_load), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    q[0].push_back({1'b1, 8'hC0});
    drive();
    repeat (30) begin
      step();
      chk("no_grant_disabled", 32'({busy, req_ready}), 0);
    end
    chk("exp_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
